serial_word_assembler: RTL and testbench
========================================

// Module: serial_word_assembler
// PURPOSE
//   Downstream stage of the 2-stage serial shift register: consumes its serial
//   tap output (q2) one bit per enabled clock and assembles WIDTH-bit words.
//   Completed words are held in a one-entry output buffer and offered with a
//   valid/ready handshake. Words that cannot be buffered are dropped and
//   flagged by a sticky overflow error.
// PARAMETERS
//   WIDTH    8   bits per assembled word (>=2)
//   MSB_FIRST 1  1: first received bit lands in dout[WIDTH-1]; 0: in dout[0]
// PORTS
//   clk         in   1          rising-edge clock
//   rst         in   1          asynchronous, active-high reset
//   din         in   1          serial data bit (from upstream q2)
//   din_en      in   1          din is valid this cycle; sample at clk rise
//   dout        out  WIDTH      assembled word; stable while dout_valid=1
//   dout_valid  out  1          output buffer holds a word
//   dout_ready  in   1          consumer accepts word when valid&ready
//   bit_cnt     out  clog2(WIDTH) bits collected in current word (0..WIDTH-1)
//   overflow    out  1          sticky: a completed word was dropped
//   clr_ovf     in   1          synchronous clear of overflow
// BEHAVIOUR
//   Reset (async, asserts immediately): shift reg=0, bit_cnt=0, dout=0,
//     dout_valid=0, overflow=0, buffer state=EMPTY. Deassertion sync to clk.
//   Shift: on clk rise with din_en=1, shift din into shift reg (direction per
//     MSB_FIRST), bit_cnt++ ; din_en=0 holds everything (no timeout).
//   Word complete: din_en=1 and bit_cnt==WIDTH-1 -> word = shifted value incl.
//     this din; bit_cnt wraps to 0; shift reg cleared.
//   Buffer FSM (EMPTY/FULL):
//     EMPTY: word complete -> dout<=word, dout_valid=1 next cycle -> FULL.
//     FULL, valid&ready, no word complete -> dout_valid=0 -> EMPTY.
//     FULL, valid&ready and word complete same cycle -> dout<=new word,
//       stay FULL, dout_valid stays 1 (back-to-back, no bubble, no overflow).
//     FULL, !ready, word complete -> new word dropped, dout unchanged,
//       overflow<=1, stay FULL.
//   Latency: dout_valid high the cycle after the edge sampling the last bit.
//   dout, dout_valid only change on handshake or buffer load; never glitch.
//   overflow: set wins over clr_ovf in the same cycle.
//   dout_ready while dout_valid=0: ignored.
//   Partial word at reset: discarded, bit_cnt restarts at 0.
// TESTING (WIDTH=4, MSB_FIRST=1 unless noted)
//   1 rst high mid-stream -> all outputs 0 same cycle; after release, bits
//     1,0,1,1 with din_en=1 -> dout=4'b1011, dout_valid=1 one cycle after 4th bit.
//   2 din_en toggling 1,0,1,0.. with bits 0,1,1,0 -> bit_cnt 1,1,2,2,3,3,0;
//     dout=4'b0110; gaps do not corrupt word.
//   3 dout_ready held 1, continuous stream 8 bits 1100_0011 -> dout=4'hC then
//     4'h3, dout_valid stays 1 across boundary, overflow=0.
//   4 dout_ready=0, send two words 1010,0101 -> dout=4'hA held, overflow=1;
//     then ready=1 -> accepted, valid=0; clr_ovf -> overflow=0.
//   5 MSB_FIRST=0, bits 1,0,0,0 -> dout=4'b0001.
//   6 Drive from shift register stage (a=3 after reset, q2 -> din, din_en=1)
//     -> after 4 bits past pipeline fill dout=4'b1111.

Source files
------------

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler with a one-entry valid/ready output buffer.
// Words completed while the buffer is held full are dropped and flagged by a sticky overflow.
module serial_word_assembler #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     din_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t        state_r;
    logic [WIDTH-1:0]  shift_r;
    logic [CW-1:0]     bit_cnt_r;
    logic [WIDTH-1:0]  dout_r;
    logic              dout_valid_r;
    logic              overflow_r;

    logic [WIDTH-1:0]  shifted_s;
    logic              word_done_s;
    logic              handshake_s;

    // Shift register contents after absorbing the current din bit.
    always_comb begin
        shifted_s = {WIDTH{1'b0}};
        if (MSB_FIRST) begin
            shifted_s = {shift_r[WIDTH-2:0], din};
        end else begin
            shifted_s = {din, shift_r[WIDTH-1:1]};
        end
    end

    assign word_done_s = din_en && (bit_cnt_r == LAST_CNT);
    assign handshake_s = dout_valid_r && dout_ready;

    // Bit collection: shift on each enabled cycle, restart cleanly at word boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
        end else if (din_en) begin
            if (word_done_s) begin
                shift_r   <= {WIDTH{1'b0}};
                bit_cnt_r <= {CW{1'b0}};
            end else begin
                shift_r   <= shifted_s;
                bit_cnt_r <= bit_cnt_r + ONE_CNT;
            end
        end else begin
            shift_r   <= shift_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Output buffer FSM with registered dout, dout_valid and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= EMPTY;
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            // The clear is scheduled first so a same-cycle drop below overrides it.
            if (clr_ovf) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            case (state_r)
                EMPTY: begin
                    if (word_done_s) begin
                        dout_r       <= shifted_s;
                        dout_valid_r <= 1'b1;
                        state_r      <= FULL;
                    end else begin
                        dout_valid_r <= 1'b0;
                        state_r      <= EMPTY;
                    end
                end
                FULL: begin
                    if (word_done_s) begin
                        if (handshake_s) begin
                            dout_r <= shifted_s;
                        end else begin
                            overflow_r <= 1'b1;
                        end
                        dout_valid_r <= 1'b1;
                        state_r      <= FULL;
                    end else if (handshake_s) begin
                        dout_valid_r <= 1'b0;
                        state_r      <= EMPTY;
                    end else begin
                        dout_valid_r <= 1'b1;
                        state_r      <= FULL;
                    end
                end
                default: begin
                    dout_valid_r <= 1'b0;
                    state_r      <= EMPTY;
                end
            endcase
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign bit_cnt    = bit_cnt_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler (WIDTH=4), MSB-first and LSB-first instances.
module tb_serial_word_assembler;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_tb;
    logic       din_en;
    logic       dout_ready;
    logic       clr_ovf;
    logic       use_up;
    logic       up_en;
    logic       up_q1;
    logic       up_q2;
    logic       din_w;
    logic [3:0] dout;
    logic       dout_valid;
    logic [1:0] bit_cnt;
    logic       overflow;

    logic       en_l;
    logic [3:0] dout_l;
    logic       dout_valid_l;
    logic [1:0] bit_cnt_l;
    logic       overflow_l;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    // Upstream 2-stage shift register with its serial input held high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            up_q1 <= 1'b0;
            up_q2 <= 1'b0;
        end else if (up_en) begin
            up_q1 <= 1'b1;
            up_q2 <= up_q1;
        end
    end

    assign din_w = use_up ? up_q2 : din_tb;

    serial_word_assembler #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din_w), .din_en(din_en),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .bit_cnt(bit_cnt), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    serial_word_assembler #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din_tb), .din_en(en_l),
        .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(1'b0),
        .bit_cnt(bit_cnt_l), .overflow(overflow_l), .clr_ovf(1'b0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din_tb = b;
        din_en = 1'b1;
        tick();
        din_en = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send_bit(w[i]);
    endtask

    logic [3:0] stream8 [8];
    logic       en_pat  [7];
    logic       din_pat [7];
    int         cnt_pat [7];

    initial begin
        rst = 1'b1; din_tb = 1'b0; din_en = 1'b0; dout_ready = 1'b0;
        clr_ovf = 1'b0; use_up = 1'b0; up_en = 1'b0; en_l = 1'b0;
        tick(); tick();
        check_val("reset_dout", dout, 4'h0);
        check_val("reset_valid", dout_valid, 1'b0);
        check_val("reset_cnt", bit_cnt, 2'd0);
        check_val("reset_ovf", overflow, 1'b0);
        rst = 1'b0;
        tick();

        // Test 1: fill buffer, leave a partial word, reset asynchronously mid-cycle.
        send_word(4'hF);
        check_val("t1_pre_dout", dout, 4'hF);
        send_bit(1'b1);
        send_bit(1'b0);
        check_val("t1_pre_cnt", bit_cnt, 2'd2);
        #2 rst = 1'b1;
        #1;
        check_val("t1_async_dout", dout, 4'h0);
        check_val("t1_async_valid", dout_valid, 1'b0);
        check_val("t1_async_cnt", bit_cnt, 2'd0);
        tick();
        rst = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check_val("t1_valid_before_last", dout_valid, 1'b0);
        send_bit(1'b1);
        check_val("t1_dout", dout, 4'b1011);
        check_val("t1_valid", dout_valid, 1'b1);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        check_val("t1_accept_valid", dout_valid, 1'b0);

        // Test 2: din_en gaps with toggling garbage on din.
        en_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        din_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        cnt_pat = '{1, 1, 2, 2, 3, 3, 0};
        for (int i = 0; i < 7; i++) begin
            din_tb = din_pat[i];
            din_en = en_pat[i];
            tick();
            check_val($sformatf("t2_cnt%0d", i), bit_cnt, cnt_pat[i]);
        end
        din_en = 1'b0;
        check_val("t2_dout", dout, 4'b0110);
        check_val("t2_valid", dout_valid, 1'b1);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;

        // Test 3a: ready held high through a continuous 8-bit stream.
        dout_ready = 1'b1;
        stream8 = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
        for (int i = 0; i < 8; i++) begin
            send_bit(stream8[i][0]);
            if (i == 3) begin
                check_val("t3_first_dout", dout, 4'hC);
                check_val("t3_first_valid", dout_valid, 1'b1);
            end
            if (i == 4) check_val("t3_consumed", dout_valid, 1'b0);
        end
        check_val("t3_second_dout", dout, 4'h3);
        check_val("t3_second_valid", dout_valid, 1'b1);
        check_val("t3_ovf", overflow, 1'b0);
        tick();
        dout_ready = 1'b0;

        // Test 3b: accept and reload on the same edge, no bubble, no overflow.
        send_word(4'hC);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        check_val("t3b_held", dout, 4'hC);
        dout_ready = 1'b1;
        send_bit(1'b1);
        check_val("t3b_dout", dout, 4'h3);
        check_val("t3b_valid", dout_valid, 1'b1);
        check_val("t3b_ovf", overflow, 1'b0);
        tick();
        dout_ready = 1'b0;
        check_val("t3b_drain", dout_valid, 1'b0);

        // Test 4: second word dropped while stalled.
        send_word(4'hA);
        send_word(4'h5);
        check_val("t4_dout", dout, 4'hA);
        check_val("t4_ovf", overflow, 1'b1);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        check_val("t4_accept_valid", dout_valid, 1'b0);
        check_val("t4_ovf_sticky", overflow, 1'b1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check_val("t4_ovf_clr", overflow, 1'b0);

        // Test 4b: a drop in the same cycle as clr_ovf leaves overflow set.
        send_word(4'h9);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        clr_ovf = 1'b1;
        send_bit(1'b0);
        clr_ovf = 1'b0;
        check_val("t4b_set_wins", overflow, 1'b1);
        check_val("t4b_dout", dout, 4'h9);
        clr_ovf = 1'b1; dout_ready = 1'b1; tick(); clr_ovf = 1'b0; dout_ready = 1'b0;
        check_val("t4b_ovf", overflow, 1'b0);

        // Test 5: LSB-first instance, first bit lands in dout[0].
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din_tb = (i == 0);
            en_l = 1'b1;
            tick();
        end
        en_l = 1'b0;
        check_val("t5_dout", dout_l, 4'b0001);
        check_val("t5_valid", dout_valid_l, 1'b1);

        // Test 6: feed from the upstream stage after its pipeline fills.
        rst = 1'b1; tick(); rst = 1'b0;
        up_en = 1'b1;
        tick(); tick();
        use_up = 1'b1;
        din_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        din_en = 1'b0;
        check_val("t6_dout", dout, 4'b1111);
        check_val("t6_valid", dout_valid, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
